// File: rtl/demux_scan_pkg.sv
// rtl/demux_scan_pkg.sv - shared constants, mode and state encodings for demux_scan_ctrl
package demux_scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] LAST_CH = 3'd7;

  // Code 11 is reserved and behaves as UP.
  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-channel dwell down-counter with reload and expire pulse
module dwell_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  // Expiry is the zero state itself, so a dwell of 1 expires every cycle.
  assign expire = run & ~load & (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load || expire) begin
      r_cnt <= value;
    end else if (run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// rtl/demux_scan_ctrl.sv - 1-to-8 demux scan sequencer; DEMUX_SCAN_ONEHOT_EN adds onehot debug output
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             single,
  input  logic [CNT_W-1:0] dwell,
  input  logic             d_in,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             d_out,
  output logic             busy,
  output logic             done
`ifdef DEMUX_SCAN_ONEHOT_EN
  ,
  output logic [NCH-1:0]   onehot
`endif
);

  logic [0:0]       r_state, w_state_d;
  logic [SEL_W-1:0] r_sel, w_sel_d, w_step_sel;
  logic             r_dir, w_dir_d, w_step_dir;
  mode_e            r_mode;
  logic             r_single;
  logic [CNT_W-1:0] r_dwm1;
  logic             r_done, w_done_d;
  logic             w_start_ok, w_load, w_expire, w_last;
  logic [CNT_W-1:0] w_tval;

  assign w_start_ok = start & ~stop & (dwell != '0);
  assign w_load     = (r_state == ST_IDLE) & w_start_ok;
  assign w_tval     = (r_state == ST_RUN) ? r_dwm1 : (dwell - CNT_W'(1));

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .run    (r_state == ST_RUN),
    .value  (w_tval),
    .expire (w_expire)
  );

  // r_dir: 0 = ascending, 1 = descending; only PINGPONG ever flips it mid-run.
  always_comb begin
    w_step_sel = r_sel + SEL_W'(1);
    w_step_dir = r_dir;
    case (r_mode)
      MODE_DOWN: w_step_sel = r_sel - SEL_W'(1);
      MODE_PP: begin
        if (!r_dir) begin
          if (r_sel == LAST_CH) begin
            w_step_sel = r_sel - SEL_W'(1);
            w_step_dir = 1'b1;
          end
        end else begin
          if (r_sel == '0) begin
            w_step_dir = 1'b0;
          end else begin
            w_step_sel = r_sel - SEL_W'(1);
          end
        end
      end
      default: w_step_sel = r_sel + SEL_W'(1);
    endcase
  end

  always_comb begin
    case (r_mode)
      MODE_DOWN: w_last = (r_sel == '0);
      MODE_PP:   w_last = r_dir & (r_sel == '0);
      default:   w_last = (r_sel == LAST_CH);
    endcase
    w_last = w_last & r_single;
  end

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_dir_d   = r_dir;
    w_done_d  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_start_ok) begin
        w_state_d = ST_RUN;
        w_sel_d   = (mode == MODE_DOWN) ? LAST_CH : '0;
        w_dir_d   = (mode == MODE_DOWN);
      end
    end else begin
      // stop outranks the end of a single pass, which suppresses done.
      if (stop) begin
        w_state_d = ST_IDLE;
      end else if (w_expire) begin
        if (w_last) begin
          w_state_d = ST_IDLE;
          w_done_d  = 1'b1;
        end else begin
          w_sel_d = w_step_sel;
          w_dir_d = w_step_dir;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_mode   <= MODE_UP;
      r_single <= 1'b0;
      r_dwm1   <= '0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_dir   <= w_dir_d;
      r_done  <= w_done_d;
      if (w_load) begin
        r_mode   <= mode_e'(mode);
        r_single <= single;
        r_dwm1   <= dwell - CNT_W'(1);
      end
    end
  end

  assign sel   = r_sel;
  assign en    = (r_state == ST_RUN);
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;
  assign d_out = d_in & en;

`ifdef DEMUX_SCAN_ONEHOT_EN
  logic [NCH-1:0] r_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot <= '0;
    end else begin
      r_onehot <= (w_state_d == ST_RUN) ? (NCH'(1) << w_sel_d) : '0;
    end
  end

  assign onehot = r_onehot;
`endif

endmodule
